// File: rtl/fft_pkg.sv
// Shared frame geometry, input-path state encoding and the bit-reverse helper
// used by the FFT input buffer.
package fft_pkg;

  localparam int FFT_STAGE = 4;
  localparam int ADDR_W    = FFT_STAGE;
  localparam int N_POINTS  = 1 << FFT_STAGE;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_FULL = 2'd2
  } state_t;

  // Mirrors the index bits; used to place samples in decimation-in-time order.
  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] value);
    logic [ADDR_W-1:0] result;
    result = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      result[i] = value[ADDR_W-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// N x WORD_SIZE sample register file: one synchronous write port, one registered
// read port, whole array cleared by the asynchronous reset.
module fft_sample_ram #(
  parameter int WORD_SIZE = 16,
  parameter int STAGE     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [STAGE-1:0]     i_wr_addr,
  input  logic [WORD_SIZE-1:0] i_wr_data,
  input  logic [STAGE-1:0]     i_rd_addr,
  output logic [WORD_SIZE-1:0] o_rd_data
);

  localparam int DEPTH = 1 << STAGE;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  // NOTE: the array sits in the reset branch because a reset must leave every
  // sample at zero; this rules out mapping the buffer onto a RAM macro.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      o_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        mem[i_wr_addr] <= i_wr_data;
      end
      // NOTE: non-blocking updates make a same-address read return the old word.
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fft_input_buffer.sv
// Pairs UART bytes into signed samples (low byte first) and holds one frame for
// the FFT core. Define FFT_INPUT_BITREV_EN to store samples in bit-reversed order.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int DATA_LENGTH = 8,
  parameter int FRACTION    = 8,
  parameter int STAGE       = FFT_STAGE
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_LENGTH-1:0] i_byte,
  input  logic                   i_byte_valid,
  input  logic                   i_byte_error,
  input  logic                   i_frame_ack,
  input  logic [STAGE-1:0]       i_rd_addr,
  output logic [WORD_SIZE-1:0]   o_rd_data,
  output logic                   o_frame_ready,
  output logic                   o_overflow
);

  // Catch parameter sets the datapath cannot represent.
  if (WORD_SIZE != 2 * DATA_LENGTH) begin : g_bad_word_size
    $error("WORD_SIZE must equal 2*DATA_LENGTH");
  end
  if (STAGE != ADDR_W) begin : g_bad_stage
    $error("STAGE must match fft_pkg::ADDR_W");
  end
  if (FRACTION > WORD_SIZE) begin : g_bad_fraction
    $error("FRACTION cannot exceed WORD_SIZE");
  end

  localparam logic [STAGE-1:0] LAST_IDX = '1;

  state_t                 state;
  logic [STAGE-1:0]       idx;
  logic [DATA_LENGTH-1:0] lo_byte;
  logic [STAGE-1:0]       wr_addr;
  logic                   wr_en;
  logic [WORD_SIZE-1:0]   wr_data;

  // A coincident framing error always kills the byte.
  assign wr_en   = (state == S_HI) && i_byte_valid && !i_byte_error;
  assign wr_data = {i_byte, lo_byte};

`ifdef FFT_INPUT_BITREV_EN
  assign wr_addr = bit_reverse(idx);
`else
  assign wr_addr = idx;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_LO;
      idx           <= '0;
      lo_byte       <= '0;
      o_frame_ready <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_overflow <= 1'b0;
      unique case (state)
        S_LO: begin
          if (i_byte_valid && !i_byte_error) begin
            lo_byte <= i_byte;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (i_byte_error) begin
            state <= S_LO;
          end else if (i_byte_valid) begin
            if (idx == LAST_IDX) begin
              state         <= S_FULL;
              o_frame_ready <= 1'b1;
            end else begin
              idx   <= idx + STAGE'(1);
              state <= S_LO;
            end
          end
        end
        S_FULL: begin
          // Every strobe while full is a dropped byte, error or not.
          o_overflow <= i_byte_valid;
          if (i_frame_ack) begin
            idx           <= '0;
            state         <= S_LO;
            o_frame_ready <= 1'b0;
          end
        end
        default: begin
          state <= S_LO;
        end
      endcase
    end
  end

  fft_sample_ram #(
    .WORD_SIZE (WORD_SIZE),
    .STAGE     (STAGE)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed bench for fft_input_buffer: frame fill, overflow, ack, error discard,
// reset mid-frame and coincident valid/error; follows FFT_INPUT_BITREV_EN.
module tb_fft_input_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_byte_error;
  logic        i_frame_ack;
  logic [3:0]  i_rd_addr;
  logic [15:0] o_rd_data;
  logic        o_frame_ready;
  logic        o_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [16];

  fft_input_buffer dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .i_byte_error  (i_byte_error),
    .i_frame_ack   (i_frame_ack),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_frame_ready (o_frame_ready),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Buffer slot that sample index k is written to.
  function automatic logic [3:0] place(input logic [3:0] k);
`ifdef FFT_INPUT_BITREV_EN
    return {k[0], k[1], k[2], k[3]};
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    i_byte       = b;
    i_byte_valid = 1'b1;
    i_byte_error = err;
    tick();
    i_byte_valid = 1'b0;
    i_byte_error = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] s);
    send_byte(s[7:0], 1'b0);
    send_byte(s[15:8], 1'b0);
  endtask

  task automatic read_addr(input logic [3:0] a, output logic [15:0] d);
    i_rd_addr = a;
    tick();
    d = o_rd_data;
  endtask

  task automatic pulse_ack();
    i_frame_ack = 1'b1;
    tick();
    i_frame_ack = 1'b0;
  endtask

  // Sends samples 0x0000, 0x0101, ... 0x0F0F and checks the ready edge.
  task automatic fill_ramp(input string tag);
    for (int j = 0; j < 16; j++) begin
      send_byte(8'(j), 1'b0);
      if (j == 15) check({tag, " ready before last byte"}, 32'(o_frame_ready), 32'd0);
      send_byte(8'(j), 1'b0);
    end
    check({tag, " ready after 32 bytes"}, 32'(o_frame_ready), 32'd1);
    check({tag, " no overflow on fill"}, 32'(o_overflow), 32'd0);
  endtask

  task automatic check_table(input string tag);
    logic [15:0] d;
    for (int i = 0; i < 16; i++) begin
      read_addr(tbl[i].addr, d);
      check($sformatf("%s rd[%0d]", tag, tbl[i].addr), 32'(d), 32'(tbl[i].exp));
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  j;

    for (int a = 0; a < 16; a++) begin
      j = place(4'(a));
      tbl[a].addr = 4'(a);
      tbl[a].exp  = {4'h0, j, 4'h0, j};
    end

    i_rst = 1'b1; i_byte = '0; i_byte_valid = 1'b0; i_byte_error = 1'b0;
    i_frame_ack = 1'b0; i_rd_addr = '0;
    tick(); tick();
    check("reset rd_data", 32'(o_rd_data), 32'd0);
    check("reset ready", 32'(o_frame_ready), 32'd0);
    check("reset overflow", 32'(o_overflow), 32'd0);
    i_rst = 1'b0;
    read_addr(4'd5, d);
    check("reset buffer[5]", 32'(d), 32'd0);

    // Frame 1: ramp fill and table readback.
    fill_ramp("fill1");
    check_table("fill1");
`ifdef FFT_INPUT_BITREV_EN
    read_addr(4'd8, d);  check("bitrev addr8", 32'(d), 32'h0101);
    read_addr(4'd12, d); check("bitrev addr12", 32'(d), 32'h0303);
`else
    read_addr(4'd8, d);  check("natural addr8", 32'(d), 32'h0808);
    read_addr(4'd12, d); check("natural addr12", 32'(d), 32'h0C0C);
`endif

    // Overflow: three dropped bytes, the last one coincident with an error.
    send_byte(8'hAA, 1'b0); check("ovf pulse 1", 32'(o_overflow), 32'd1);
    send_byte(8'hBB, 1'b0); check("ovf pulse 2", 32'(o_overflow), 32'd1);
    send_byte(8'hCC, 1'b1); check("ovf pulse 3 (with error)", 32'(o_overflow), 32'd1);
    tick();
    check("ovf clears", 32'(o_overflow), 32'd0);
    check("ready held while full", 32'(o_frame_ready), 32'd1);
    check_table("after ovf");

    pulse_ack();
    check("ready falls after ack", 32'(o_frame_ready), 32'd0);

    // Error discards a latched low byte; collision read returns old word.
    send_byte(8'h34, 1'b0);
    i_byte_error = 1'b1;
    tick();
    i_byte_error = 1'b0;
    send_byte(8'h78, 1'b0);
    i_rd_addr = 4'd0;
    send_byte(8'h56, 1'b0);
    check("same-addr read returns old", 32'(o_rd_data), 32'h0000);
    read_addr(4'd0, d);
    check("error discard sample0", 32'(d), 32'h5678);
    send_sample(16'hBEEF);
    read_addr(place(4'd1), d);
    check("sample1 after ack", 32'(d), 32'hBEEF);
    read_addr(place(4'd2), d);
    check("old sample2 persists", 32'(d), 32'h0202);

    // Ack outside S_FULL must not rewind idx: 14 more samples complete the frame.
    pulse_ack();
    check("ack ignored when not full", 32'(o_frame_ready), 32'd0);
    for (int i = 2; i < 16; i++) begin
      send_sample(16'h1000 + 16'(i));
      if (i == 14) check("ready before sample15", 32'(o_frame_ready), 32'd0);
    end
    check("ready after 14 more samples", 32'(o_frame_ready), 32'd1);
    read_addr(place(4'd15), d);
    check("frame2 sample15", 32'(d), 32'h100F);
    read_addr(4'd0, d);
    check("frame2 sample0 kept", 32'(d), 32'h5678);
    pulse_ack();

    // Reset mid-frame after 11 bytes clears everything immediately.
    for (int b = 0; b < 11; b++) send_byte(8'hF0 + 8'(b), 1'b0);
    i_rst = 1'b1;
    #1;
    check("mid reset rd_data", 32'(o_rd_data), 32'd0);
    check("mid reset ready", 32'(o_frame_ready), 32'd0);
    check("mid reset overflow", 32'(o_overflow), 32'd0);
    tick();
    i_rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      read_addr(4'(a), d);
      check($sformatf("cleared rd[%0d]", a), 32'(d), 32'd0);
    end
    fill_ramp("fill3");
    check_table("fill3");
    pulse_ack();
    check("ready falls after ack 3", 32'(o_frame_ready), 32'd0);

    // Coincident valid/error on byte 5 drops that byte: 33 bytes needed.
    for (int b = 1; b <= 32; b++) send_byte(8'(b), (b == 5));
    check("coincident: not ready at 32", 32'(o_frame_ready), 32'd0);
    send_byte(8'd33, 1'b0);
    check("coincident: ready at 33", 32'(o_frame_ready), 32'd1);
    read_addr(place(4'd1), d);
    check("coincident sample1", 32'(d), 32'h0403);
    read_addr(place(4'd2), d);
    check("coincident sample2", 32'(d), 32'h0706);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_input_buffer.md
# fft_input_buffer

Collects bytes from the UART receiver, pairs them into signed WORD_SIZE-bit samples (low byte first), and stores one 2**STAGE-point frame in an internal buffer. When the frame is complete it raises a ready flag and holds it until the FFT core acknowledges. The FFT core reads samples through a registered random-access port. The block sits between UART_RX and the FFT core in the top level.

## Interface
- WORD_SIZE, 16, sample width; must equal 2*DATA_LENGTH.
- DATA_LENGTH, 8, UART byte width.
- FRACTION, 8, fractional bits of the sample format. Documentation only; samples are not altered.
- STAGE, 4, log2 of frame length (N = 2**STAGE = 16).
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_byte  in  DATA_LENGTH  received byte.
- i_byte_valid  in  1  one-cycle strobe; i_byte is valid this cycle.
- i_byte_error  in  1  one-cycle strobe; framing error reported by the receiver.
- i_frame_ack  in  1  one-cycle strobe from the FFT core: frame consumed.
- i_rd_addr  in  STAGE  sample read address.
- o_rd_data  out  WORD_SIZE  sample at the previous cycle's i_rd_addr.
- o_frame_ready  out  1  level; a full frame is held.
- o_overflow  out  1  one-cycle pulse for each byte dropped while full.

## Operation
- State machine, with reset state S_LO:
  - S_LO: on i_byte_valid, latch i_byte as the low byte and go to S_HI.
  - S_HI: on i_byte_valid, write {i_byte, low} to buffer[wr_addr(idx)] and increment idx. If idx was N-1, go to S_FULL; otherwise return to S_LO.
  - S_FULL: drop every i_byte_valid and pulse o_overflow. On i_frame_ack, set idx to 0 and go to S_LO.
- i_byte_error:
  - In S_HI: discard the latched low byte and return to S_LO. idx is unchanged.
  - In S_LO or S_FULL: ignored.
- i_byte_valid and i_byte_error in the same cycle: the error wins and the byte is discarded. In S_FULL, o_overflow still pulses.
- i_frame_ack outside S_FULL: ignored.
- idx is STAGE bits wide and never wraps while filling; the transition to S_FULL happens at idx = N-1.
- Buffer contents persist after ack and are overwritten sample by sample as the next frame arrives.
- The read port is always active, regardless of state.
- Sample format: two's complement, {hi, lo}. No sign extension, saturation, or scaling.

## Timing
- Reset values:
  - o_rd_data = 0, o_frame_ready = 0, o_overflow = 0.
  - All buffer entries = 0, idx = 0, state = S_LO.
- Reset takes effect mid-frame with no delay: the partial frame is lost and the buffer is cleared.
- A buffer write occurs on the clock edge that samples the high-byte strobe.
- o_frame_ready is 1 exactly while the state is S_FULL:
  - It rises in the cycle after the edge that captured the 2N-th accepted byte.
  - It falls in the cycle after the edge that sampled i_frame_ack.
- Read latency: 1 cycle. o_rd_data at cycle k+1 equals buffer[i_rd_addr at cycle k].
- A read and a write to the same address in the same cycle return the old contents.
- The earliest next-frame byte accepted is in the cycle after the ack edge.
- o_overflow is registered: it is high the cycle after the dropped strobe.

## Configuration
- FFT_INPUT_BITREV_EN defined: wr_addr(idx) = bit-reverse of idx over STAGE bits. The buffer is in decimation-in-time input order for the FFT core.
- Not defined: wr_addr(idx) = idx (natural order). The FFT core performs its own reordering.

## Structure
- Shared package fft_pkg holds:
  - N_POINTS and ADDR_W constants, derived from STAGE.
  - the state encoding (S_LO, S_HI, S_FULL).
  - a bit-reverse function parameterised on ADDR_W.
- Sub-module fft_sample_ram: N x WORD_SIZE register file with one synchronous write port and one registered read port, and asynchronous clear on i_rst.
- The FSM, byte latch, and idx counter live in fft_input_buffer.

## Test plan
- Fill: send 32 bytes forming samples 0x0000, 0x0101, …, 0x0F0F with BITREV_EN set -> o_frame_ready = 1. Reading address 8 gives 0x0101; address 12 gives 0x0303; address 0 gives 0x0000.
- Same stimulus without BITREV_EN -> address k reads 0x0k0k for every k.
- While full, send 3 more bytes -> 3 o_overflow pulses and buffer unchanged. Then pulse i_frame_ack -> o_frame_ready = 0 on the next cycle, and the next 2 bytes land at index 0.
- Send low byte 0x34, then pulse i_byte_error, then send bytes 0x78, 0x56 -> sample 0 = 0x5678.
- Assert i_rst after 11 bytes -> all outputs 0 and all reads return 0. A fresh 32-byte frame then completes normally.
- Send 32 bytes with i_byte_valid and i_byte_error coincident on byte 5 -> o_frame_ready stays 0 until a 33rd valid byte arrives.
